// File: rtl/reset_seq_pkg.sv
// Shared types and helpers for the reset sequencer.
package reset_seq_pkg;

   typedef enum logic [1:0] {StAssert, StRelease, StRun} state_e;

   localparam int unsigned LOSS_CNT_W = 8;

   // Bits needed to hold 0..max_val, never less than one.
   function automatic int unsigned cnt_w(input int unsigned max_val);
      return (max_val < 1) ? 1 : unsigned'($clog2(max_val + 1));
   endfunction

endpackage

// File: rtl/sync_ff.sv
// Multi-flop single-bit synchroniser, synchronously cleared to 0.
module sync_ff #(
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic clock,
   input  logic reset,
   input  logic d_i,
   output logic q_o
);

   logic [SYNC_STAGES-1:0] sync_q;

   always_ff @(posedge clock) begin
      if (reset) sync_q <= '0;
      else       sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
   end

   assign q_o = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/reset_sequencer.sv
// Chip-level reset sequencer: filters PLL lock, holds all domains in reset for a minimum
// time, then releases them one by one; any abort re-asserts every domain.
module reset_sequencer import reset_seq_pkg::*; #(
   parameter int unsigned N_CH        = 4,
   parameter int unsigned HOLD_CYC    = 16,
   parameter int unsigned LOCK_FILT   = 8,
   parameter int unsigned GAP_CYC     = 4,
   parameter int unsigned SYNC_STAGES = 2
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  pll_locked_i,
   input  logic                  ext_rst_i,
   input  logic                  soft_rst_req_i,
   output logic [N_CH-1:0]       rst_o,
   output logic                  all_released_o,
   output logic [LOSS_CNT_W-1:0] lock_loss_cnt_o
);

   localparam int unsigned HoldW = cnt_w(HOLD_CYC);
   localparam int unsigned FiltW = cnt_w(LOCK_FILT);
   localparam int unsigned GapW  = cnt_w(GAP_CYC - 1);
   localparam int unsigned IdxW  = cnt_w(N_CH - 1);

   localparam logic [HoldW-1:0]      HoldMax = HoldW'(HOLD_CYC);
   localparam logic [FiltW-1:0]      FiltMax = FiltW'(LOCK_FILT);
   localparam logic [GapW-1:0]       GapLast = GapW'(GAP_CYC - 1);
   localparam logic [IdxW-1:0]       IdxLast = IdxW'(N_CH - 1);
   localparam logic [LOSS_CNT_W-1:0] LossMax = '1;

   logic lk_s, er_s;
   logic lock_ok, abort, lk_fall;

   state_e                  state_q, state_d;
   logic [HoldW-1:0]        hold_q, hold_d;
   logic [FiltW-1:0]        lk_cnt_q, lk_cnt_d;
   logic [GapW-1:0]         gap_q, gap_d;
   logic [IdxW-1:0]         idx_q, idx_d;
   logic [N_CH-1:0]         rst_q, rst_d;
   logic                    all_rel_q;
   logic [LOSS_CNT_W-1:0]   loss_q, loss_d;
   logic                    lk_prev_q;

   sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lock (
      .clock (clock),
      .reset (reset),
      .d_i   (pll_locked_i),
      .q_o   (lk_s)
   );

   sync_ff #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ext (
      .clock (clock),
      .reset (reset),
      .d_i   (ext_rst_i),
      .q_o   (er_s)
   );

   assign lock_ok = (lk_cnt_q == FiltMax);
   assign abort   = ~lk_s | er_s | soft_rst_req_i;
   assign lk_fall = lk_prev_q & ~lk_s;

   always_comb begin
      lk_cnt_d = lk_cnt_q;
      if (!lk_s)                   lk_cnt_d = '0;
      else if (lk_cnt_q != FiltMax) lk_cnt_d = lk_cnt_q + FiltW'(1);

      // Only losses after release has begun are counted.
      loss_d = loss_q;
      if (lk_fall && state_q != StAssert && loss_q != LossMax) loss_d = loss_q + LOSS_CNT_W'(1);
   end

   always_comb begin
      state_d = state_q;
      hold_d  = '0;
      gap_d   = '0;
      idx_d   = '0;
      rst_d   = rst_q;
      unique case (state_q)
         StAssert: begin
            rst_d = '1;
            if (!abort) begin
               hold_d = (hold_q != HoldMax) ? hold_q + HoldW'(1) : hold_q;
               // Leave on the edge where the hold count completes, so domain 0 drops at once.
               if (hold_d == HoldMax && lock_ok) begin
                  state_d  = StRelease;
                  rst_d[0] = 1'b0;
               end
            end
         end
         StRelease: begin
            if (abort) begin
               state_d = StAssert;
               rst_d   = '1;
            end else if (idx_q == IdxLast) begin
               state_d = StRun;
               rst_d   = '0;
            end else if (gap_q == GapLast) begin
               idx_d        = idx_q + IdxW'(1);
               rst_d[idx_d] = 1'b0;
               if (idx_d == IdxLast) state_d = StRun;
            end else begin
               idx_d = idx_q;
               gap_d = gap_q + GapW'(1);
            end
         end
         StRun: begin
            rst_d = '0;
            if (abort) begin
               state_d = StAssert;
               rst_d   = '1;
            end
         end
         default: begin
            state_d = StAssert;
            rst_d   = '1;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= StAssert;
         hold_q    <= '0;
         lk_cnt_q  <= '0;
         gap_q     <= '0;
         idx_q     <= '0;
         rst_q     <= '1;
         all_rel_q <= 1'b0;
         loss_q    <= '0;
         lk_prev_q <= 1'b0;
      end else begin
         state_q   <= state_d;
         hold_q    <= hold_d;
         lk_cnt_q  <= lk_cnt_d;
         gap_q     <= gap_d;
         idx_q     <= idx_d;
         rst_q     <= rst_d;
         all_rel_q <= (rst_d == '0);
         loss_q    <= loss_d;
         lk_prev_q <= lk_s;
      end
   end

   assign rst_o           = rst_q;
   assign all_released_o  = all_rel_q;
   assign lock_loss_cnt_o = loss_q;

endmodule

// File: tb/tb_reset_sequencer.sv
// Directed scoreboard bench: expected output snapshots are queued per cycle and checked at negedge.
module tb_reset_sequencer;

   localparam int N    = 4;
   localparam int HOLD = 16;
   localparam int FILT = 8;
   localparam int GAP  = 4;
   localparam int SS   = 2;
   localparam int T0   = ((HOLD > SS + FILT) ? HOLD : SS + FILT) + 1;

   logic         clock = 1'b0;
   logic         reset = 1'b1;
   logic         pll_locked_i = 1'b1;
   logic         ext_rst_i = 1'b0;
   logic         soft_rst_req_i = 1'b0;
   logic [N-1:0] rst_o;
   logic         all_released_o;
   logic [7:0]   lock_loss_cnt_o;

   int cyc = -1;
   int n_assert = 0;
   int n_fail = 0;

   typedef struct {
      int         at;
      logic [N-1:0] rst;
      logic       all_rel;
      logic [7:0] cnt;
      string      tag;
   } exp_t;

   exp_t sb[$];

   reset_sequencer #(
      .N_CH        (N),
      .HOLD_CYC    (HOLD),
      .LOCK_FILT   (FILT),
      .GAP_CYC     (GAP),
      .SYNC_STAGES (SS)
   ) dut (
      .clock           (clock),
      .reset           (reset),
      .pll_locked_i    (pll_locked_i),
      .ext_rst_i       (ext_rst_i),
      .soft_rst_req_i  (soft_rst_req_i),
      .rst_o           (rst_o),
      .all_released_o  (all_released_o),
      .lock_loss_cnt_o (lock_loss_cnt_o)
   );

   always #5 clock = ~clock;

   // Cycle 0 is the cycle after the first edge that samples reset low.
   always @(posedge clock) cyc <= reset ? -1 : cyc + 1;

   function automatic logic [N-1:0] mask(input int k);
      logic [N-1:0] m;
      m = '1;
      return m << k;
   endfunction

   function automatic logic [7:0] sat(input int k);
      return (k > 255) ? 8'd255 : 8'(k);
   endfunction

   task automatic push(input int at, input logic [N-1:0] rst, input logic [7:0] cnt,
                       input string tag);
      exp_t e;
      e.at = at; e.rst = rst; e.all_rel = (rst == '0); e.cnt = cnt; e.tag = tag;
      sb.push_back(e);
   endtask

   // Expected staggered release of the first nk domains, domain 0 falling at r0.
   task automatic push_rel(input int r0, input logic [7:0] cnt, input int nk, input string tag);
      for (int k = 0; k < nk; k++) begin
         push(r0 + k * GAP - 1, mask(k), cnt, {tag, "_pre"});
         push(r0 + k * GAP, mask(k + 1), cnt, {tag, "_rel"});
      end
   endtask

   task automatic check_now();
      exp_t e;
      while (sb.size() > 0 && sb[0].at <= cyc) begin
         e = sb.pop_front();
         n_assert++;
         assert (e.at == cyc && rst_o === e.rst && all_released_o === e.all_rel &&
                 lock_loss_cnt_o === e.cnt)
         else begin
            n_fail++;
            $error("FAIL %s cyc=%0d due=%0d: got rst_o=%h all_released_o=%b cnt=%0d, want rst_o=%h all_released_o=%b cnt=%0d",
                   e.tag, cyc, e.at, rst_o, all_released_o, lock_loss_cnt_o, e.rst, e.all_rel,
                   e.cnt);
         end
      end
   endtask

   task automatic step();
      @(negedge clock);
      check_now();
      @(posedge clock);
      #1;
   endtask

   task automatic run_to(input int t);
      while (cyc < t) step();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      step();
      push(-1, '1, 8'd0, "reset_state");
      step();
      reset = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL timeout: bench did not complete");
      $fatal(1, "bench timeout");
   end

   initial begin
      int c;
      do_reset();

      // Clean power-up release: domains fall at 17, 21, 25, 29.
      push_rel(T0, 8'd0, N, "t1");
      run_to(T0 + (N - 1) * GAP + 1);

      // Three-cycle lock loss in RUN.
      run_to(32);
      push(34, '0, 8'd0, "t3_pre_abort");
      push(35, '1, 8'd1, "t3_abort");
      push_rel(36 + HOLD + 1, 8'd1, N, "t3");
      pll_locked_i = 1'b0;
      run_to(35);
      pll_locked_i = 1'b1;
      run_to(66);

      // Soft request mid-release, after domain 1 has dropped.
      push(67, '1, 8'd1, "t4_soft_run");
      push_rel(83, 8'd1, 2, "t4a");
      push(88, mask(2), 8'd1, "t4_mid_rel");
      push(89, '1, 8'd1, "t4_abort");
      push_rel(88 + HOLD + 1, 8'd1, N, "t4b");
      soft_rst_req_i = 1'b1;
      run_to(67);
      soft_rst_req_i = 1'b0;
      run_to(88);
      soft_rst_req_i = 1'b1;
      run_to(89);
      soft_rst_req_i = 1'b0;
      run_to(118);

      // Board reset held 50 cycles in RUN.
      run_to(120);
      push(121, '0, 8'd1, "t5_pre");
      push(122, '0, 8'd1, "t5_sync");
      push(123, '1, 8'd1, "t5_abort");
      push(150, '1, 8'd1, "t5_hold");
      push(171, '1, 8'd1, "t5_last");
      push_rel(171 + HOLD + 1, 8'd1, N, "t5");
      ext_rst_i = 1'b1;
      run_to(170);
      ext_rst_i = 1'b0;
      run_to(201);

      // Soft request held five cycles acts as one sustained abort.
      run_to(202);
      push(202, '0, 8'd1, "t5b_pre");
      push(203, '1, 8'd1, "t5b_abort");
      push(206, '1, 8'd1, "t5b_hold");
      push_rel(206 + HOLD + 1, 8'd1, N, "t5b");
      soft_rst_req_i = 1'b1;
      run_to(207);
      soft_rst_req_i = 1'b0;
      run_to(236);

      // One-cycle lock glitch before release restarts filter and hold; not counted.
      do_reset();
      push(16, '1, 8'd0, "t2_held");
      push(T0, '1, 8'd0, "t2_no_early");
      push_rel(8 + SS + HOLD + 1, 8'd0, N, "t2");
      run_to(8);
      pll_locked_i = 1'b0;
      run_to(9);
      pll_locked_i = 1'b1;
      run_to(40);

      // 300 lock losses from RUN: counter saturates at 255.
      for (int k = 1; k <= 300; k++) begin
         c = cyc;
         push(c + 3, '1, sat(k), "t6_abort");
         push(c + 2 + HOLD + 1 + (N - 1) * GAP, '0, sat(k), "t6_run");
         pll_locked_i = 1'b0;
         run_to(c + 1);
         pll_locked_i = 1'b1;
         run_to(c + 2 + HOLD + 1 + (N - 1) * GAP + 1);
      end

      // Synchronous reset in the middle of a release.
      c = cyc;
      push_rel(c + HOLD + 1, 8'd255, 2, "t6r");
      push(c + HOLD + 6, mask(2), 8'd255, "t6r_before_reset");
      soft_rst_req_i = 1'b1;
      run_to(c + 1);
      soft_rst_req_i = 1'b0;
      run_to(c + HOLD + 6);
      reset = 1'b1;
      step();
      push(-1, '1, 8'd0, "t6r_reset_state");
      step();
      reset = 1'b0;
      push_rel(T0, 8'd0, N, "t6r_again");
      run_to(T0 + (N - 1) * GAP + 1);

      n_assert++;
      assert (sb.size() == 0)
      else begin
         n_fail++;
         $error("FAIL scoreboard_drain: %0d entries left, want 0", sb.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
